// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipeline stage registers
package pipe_pkg;

    localparam int MEM_CTRL_W = 5;

    typedef struct packed {
        logic size;
        logic enable;
        logic rw;
        logic load;
        logic rf;
    } mem_ctrl_t;

    localparam mem_ctrl_t MEM_CTRL_NOP = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    // Occupancy is fully described by the two valid bits; skid-only maps to FULL
    // so that the illegal combination never hides behind EMPTY.
    function automatic stage_state_t stage_state(input logic main_v, input logic skid_v);
        if (skid_v) begin
            return ST_FULL;
        end else if (main_v) begin
            return ST_HALF;
        end else begin
            return ST_EMPTY;
        end
    endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - one valid+ctrl+data holding register with load and clear
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = MEM_CTRL_W,
    parameter int                DATA_W   = 32,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);

    logic              valid_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic [DATA_W-1:0] data_d;

    // Clear wins over load; data is left alone on clear so data_o holds its last value.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_RST;
        end else if (load) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_in;
            data_d  = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_RST;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready stage register with 2-entry skid; PIPE_STAGE_BUBBLE_CNT_EN adds bubble_cnt_o
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = MEM_CTRL_W,
    parameter int                DATA_W   = 32,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    input  logic              flush_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    output logic [15:0]       bubble_cnt_o,
`endif
    input  logic              ready_i
);

    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;

    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [DATA_W-1:0] main_data_in;
    logic              in_fire, out_fire;
    stage_state_t      state;

    assign state    = stage_state(main_valid, skid_valid);
    assign ready_o  = CLR & ~skid_valid;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = main_valid & ready_i;

    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush_i) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    main_load = in_fire;
                end
                ST_HALF: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                    end
                end
                ST_FULL: begin
                    // ready_o is low here, so only the drain path can move
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        main_ctrl_in = ctrl_i;
        main_data_in = data_i;
        if (main_from_skid) begin
            main_ctrl_in = skid_ctrl;
            main_data_in = skid_data;
        end
    end

    pipe_skid_entry #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST (CTRL_RST)
    ) u_main (
        .clk     (CLK),
        .resetn  (CLR),
        .load    (main_load),
        .clear   (main_clear),
        .ctrl_in (main_ctrl_in),
        .data_in (main_data_in),
        .valid_q (main_valid),
        .ctrl_q  (main_ctrl),
        .data_q  (main_data)
    );

    pipe_skid_entry #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST (CTRL_RST)
    ) u_skid (
        .clk     (CLK),
        .resetn  (CLR),
        .load    (skid_load),
        .clear   (skid_clear),
        .ctrl_in (ctrl_i),
        .data_in (data_i),
        .valid_q (skid_valid),
        .ctrl_q  (skid_ctrl),
        .data_q  (skid_data)
    );

    assign valid_o = main_valid;
    assign data_o  = main_data;

    always_comb begin
        ctrl_o = CTRL_RST;
        if (main_valid) begin
            ctrl_o = main_ctrl;
        end
    end

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!main_valid && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
`endif

    always_ff @(posedge CLK) begin
        if (CLR) begin
            assert (!(skid_valid && !main_valid))
                else $error("pipe_stage_reg: skid entry valid while main entry empty");
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int CTRL_W = 5;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              CLR;
    logic              valid_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_i;
    logic              ready_o;
    logic              flush_i;
    logic              valid_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_o;
    logic              ready_i;
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    logic [15:0]       bubble_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    pipe_stage_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST (5'b00000)
    ) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .valid_i (valid_i),
        .ctrl_i  (ctrl_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .flush_i (flush_i),
        .valid_o (valid_o),
        .ctrl_o  (ctrl_o),
        .data_o  (data_o),
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
        .bubble_cnt_o (bubble_cnt_o),
`endif
        .ready_i (ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] c, input logic [31:0] d);
        valid_i = v;
        ctrl_i  = c;
        data_i  = d;
    endtask

    initial begin
        CLR = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        drive(1'b1, 5'b11111, 32'h99);

        // reset holds outputs at NOP even with a beat offered
        tick(); tick();
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_ctrl",  {27'd0, ctrl_o}, 32'd0);
        chk("rst_data",  data_o, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        CLR = 1'b1;
        drive(1'b0, 5'd0, 32'd0);
        tick();
        chk("rel_ready", {31'd0, ready_o}, 32'd1);
        chk("rel_valid", {31'd0, valid_o}, 32'd0);

        // streaming: one beat per cycle, one-cycle latency
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(k + 1), 32'h10 + 32'(k));
            chk($sformatf("str_ready%0d", k), {31'd0, ready_o}, 32'd1);
            tick();
            chk($sformatf("str_valid%0d", k), {31'd0, valid_o}, 32'd1);
            chk($sformatf("str_data%0d", k), data_o, 32'h10 + 32'(k));
            chk($sformatf("str_ctrl%0d", k), {27'd0, ctrl_o}, 32'(k + 1));
        end
        drive(1'b0, 5'd0, 32'd0);
        tick();
        chk("str_drain", {31'd0, valid_o}, 32'd0);

        // stall: A in main, B in skid, C held upstream
        ready_i = 1'b0;
        drive(1'b1, 5'h03, 32'hA);
        tick();
        chk("stl_a_valid", {31'd0, valid_o}, 32'd1);
        chk("stl_a_data", data_o, 32'hA);
        chk("stl_rdy_half", {31'd0, ready_o}, 32'd1);
        drive(1'b1, 5'h05, 32'hB);
        tick();
        chk("stl_rdy_full", {31'd0, ready_o}, 32'd0);
        chk("stl_hold_a", data_o, 32'hA);
        drive(1'b1, 5'h07, 32'hC);
        tick();
        chk("stl_still_a", data_o, 32'hA);
        chk("stl_still_ctrl", {27'd0, ctrl_o}, 32'h03);
        ready_i = 1'b1;
        tick();
        chk("stl_out_b", data_o, 32'hB);
        chk("stl_ctrl_b", {27'd0, ctrl_o}, 32'h05);
        chk("stl_rdy_back", {31'd0, ready_o}, 32'd1);
        tick();
        chk("stl_out_c", data_o, 32'hC);
        chk("stl_valid_c", {31'd0, valid_o}, 32'd1);
        drive(1'b0, 5'd0, 32'd0);
        tick();
        chk("stl_empty", {31'd0, valid_o}, 32'd0);

        // flush in FULL discards both entries and the offered beat
        ready_i = 1'b0;
        drive(1'b1, 5'h15, 32'hA); tick();
        drive(1'b1, 5'h0A, 32'hB); tick();
        chk("fl_full_rdy", {31'd0, ready_o}, 32'd0);
        flush_i = 1'b1;
        drive(1'b1, 5'h1F, 32'hD);
        tick();
        flush_i = 1'b0;
        chk("fl_valid", {31'd0, valid_o}, 32'd0);
        chk("fl_ctrl", {27'd0, ctrl_o}, 32'd0);
        chk("fl_ready", {31'd0, ready_o}, 32'd1);
        drive(1'b0, 5'd0, 32'd0);
        ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl_no_d%0d", k), {31'd0, valid_o}, 32'd0);
        end

        // reset while FULL and stalled
        ready_i = 1'b0;
        drive(1'b1, 5'h11, 32'h1); tick();
        drive(1'b1, 5'h12, 32'h2); tick();
        chk("rm_full_rdy", {31'd0, ready_o}, 32'd0);
        CLR = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        tick();
        chk("rm_valid", {31'd0, valid_o}, 32'd0);
        chk("rm_ctrl", {27'd0, ctrl_o}, 32'd0);
        chk("rm_data", data_o, 32'd0);
        chk("rm_ready", {31'd0, ready_o}, 32'd0);
        CLR = 1'b1;
        ready_i = 1'b1;
        drive(1'b1, 5'h09, 32'h55);
        tick();
        chk("rm_55_valid", {31'd0, valid_o}, 32'd1);
        chk("rm_55_data", data_o, 32'h55);
        chk("rm_55_ctrl", {27'd0, ctrl_o}, 32'h09);
        drive(1'b0, 5'd0, 32'd0);
        tick();
        chk("rm_55_once", {31'd0, valid_o}, 32'd0);

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
        CLR = 1'b0;
        tick();
        chk("bc_rst", {16'd0, bubble_cnt_o}, 32'd0);
        CLR = 1'b1;
        tick(); tick(); tick();
        chk("bc_three", {16'd0, bubble_cnt_o}, 32'd3);
        repeat (65540) @(posedge CLK);
        #1;
        chk("bc_sat", {16'd0, bubble_cnt_o}, 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the EX/MEM (and other) stage boundaries. It carries a control bundle and a data payload with a valid/ready handshake. A 2-entry skid buffer lets a downstream stall apply without a combinational ready path. Flush inserts bubbles, and bubbles always present the reset control value (a NOP: no memory enable, no write, no regfile write).

Parameters:
CTRL_W, 5, width of control bundle (size, enable, rw, load, rf in MEM-stage use)
DATA_W, 32, width of data payload (ALU result / store data)
CTRL_RST, {CTRL_W{1'b0}}, control value driven for bubbles, flush and reset

Ports:
CLK  in  1  clock, all state updates on rising edge
CLR  in  1  synchronous reset, active-low
valid_i  in  1  upstream beat valid
ctrl_i  in  CTRL_W  upstream control bundle
data_i  in  DATA_W  upstream payload
ready_o  out  1  stage can accept a beat this cycle
flush_i  in  1  kill all held beats (branch taken / exception)
valid_o  out  1  downstream beat valid
ctrl_o  out  CTRL_W  downstream control bundle
data_o  out  DATA_W  downstream payload
ready_i  in  1  downstream accepts; 0 = stall

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each holding valid + ctrl + data.
- Transfer rules: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- ready_o = CLR & ~skid_valid. It depends on registered state and CLR only, never on ready_i.
- valid_o = main_valid. ctrl_o = main_valid ? main_ctrl : CTRL_RST. data_o = main_data (holds last value when invalid).
- States are derived from the valid bits: EMPTY (main=0, skid=0), HALF (main=1, skid=0), FULL (both=1). main=0 with skid=1 is illegal and must never occur.
- EMPTY:
  - in_fire -> main <= input; go to HALF.
  - Otherwise stay in EMPTY.
- HALF:
  - in_fire & out_fire -> main <= input; stay in HALF.
  - in_fire & ~out_fire -> skid <= input; go to FULL.
  - ~in_fire & out_fire -> go to EMPTY.
  - Neither -> hold.
- FULL (ready_o=0, so no in_fire):
  - out_fire -> main <= skid, skid cleared; go to HALF.
  - Otherwise hold.
- Latency: 1 cycle from in_fire to valid_o when the stage is not stalled.
- Ordering: beats leave in arrival order. No beat is dropped or duplicated except by flush.
- Flush:
  - When flush_i=1 (and CLR=1), next state is EMPTY and ctrl of both entries <= CTRL_RST, whatever in_fire/out_fire are.
  - A beat offered in a flush cycle is discarded. The upstream stage is flushed in the same cycle by the hazard unit.
  - A beat already on the outputs in the flush cycle may still be consumed downstream that cycle (out_fire is honoured combinationally).
- Reset (CLR=0 at a rising edge):
  - main_valid=0, skid_valid=0, ctrl entries=CTRL_RST, data entries=0.
  - Outputs after the edge: valid_o=0, ctrl_o=CTRL_RST, data_o=0.
  - ready_o=0 for the whole time CLR is low.
  - Reset mid-transfer discards both entries. Reset has priority over flush.
- Back-to-back: sustains 1 beat/cycle while ready_i=1. Throughput never drops below 1 beat/cycle after a stall ends.

Optional Feature:
PIPE_STAGE_BUBBLE_CNT_EN:
- Defined: adds output bubble_cnt_o [15:0], a saturating count of cycles with valid_o=0 while CLR=1. It resets to 0, saturates at 16'hFFFF, and a flush cycle counts as a bubble on the following cycle. Used for CPI profiling.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg:
  - mem_ctrl_t packed struct {size, enable, rw, load, rf}.
  - MEM_CTRL_W = 5.
  - MEM_CTRL_NOP = '0.
  - Stage state enum {ST_EMPTY, ST_HALF, ST_FULL}, used for assertions/debug.
- One natural sub-module: pipe_skid_entry (valid + ctrl + data register with load/clear). It is instantiated twice for main and skid.

Test Plan:
- Reset/NOP: hold CLR=0 for 2 cycles with valid_i=1, ctrl_i=5'b11111 -> valid_o=0, ctrl_o=5'b00000, data_o=0, ready_o=0. Release -> ready_o=1 next cycle.
- Streaming: ready_i=1, feed data 0x10..0x13 on consecutive cycles -> data_o shows 0x10..0x13 one cycle later, valid_o continuously 1, ready_o always 1.
- Stall/skid: feed 0xA, 0xB, 0xC with ready_i=0 from the cycle 0xA appears -> ready_o falls after 0xB is accepted, 0xC is held upstream. Raise ready_i -> outputs 0xA, 0xB, 0xC in order, no loss or duplication.
- Flush in FULL: entries 0xA/0xB held, flush_i=1 with valid_i=1 (0xD), ready_i=0 -> next cycle valid_o=0, ctrl_o=CTRL_RST, ready_o=1, 0xD never appears.
- Reset mid-stall: FULL state, CLR=0 one cycle -> EMPTY, all outputs at reset values. Subsequent beat 0x55 passes with 1-cycle latency.
- Feature (PIPE_STAGE_BUBBLE_CNT_EN defined): 3 idle cycles after reset -> bubble_cnt_o=3. Force the count to 16'hFFFF -> it stays at 16'hFFFF.
